mem_burst_arbiter: RTL and testbench

Shares the single MainMemory port between instruction-cache line refills and data-cache line refills and writebacks. Each granted requester gets one full cache-line burst of WORDS_PER_LINE sequential words. The block drives main-memory read/write enables, the word address, write data and the inter-beat delay-counter restart. It sits between CacheController/CacheLineAdapter and MainMemory, and replaces ad-hoc re_mm/we_data_mm/reset_mm sequencing.

---
 rtl/mem_burst_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_burst_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: shares the single main-memory port between I-cache line
// refills and D-cache line refills/writebacks. The owner of each grant gets one
// full burst of WORDS_PER_LINE sequential words. Ties alternate between I and D.
module mem_burst_arbiter #(
    parameter int unsigned WORDS_PER_LINE = 8,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic                              MEM_CLK,
    input  logic                              RST,
    input  logic                              i_req,
    input  logic [ADDR_W-1:0]                 i_addr,
    input  logic                              d_req,
    input  logic                              d_we,
    input  logic [ADDR_W-1:0]                 d_addr,
    input  logic [31:0]                       d_wdata,
    output logic                              i_gnt,
    output logic                              d_gnt,
    output logic [$clog2(WORDS_PER_LINE)-1:0] beat,
    output logic [31:0]                       rd_data,
    output logic                              rd_valid,
    output logic                              done_i,
    output logic                              done_d,
    output logic                              busy,
    output logic                              mm_re,
    output logic                              mm_we,
    output logic [ADDR_W-1:0]                 mm_addr,
    output logic [31:0]                       mm_din,
    input  logic [31:0]                       mm_dout,
    input  logic                              mm_valid,
    output logic                              mm_rst
);

    localparam int unsigned BEAT_W = $clog2(WORDS_PER_LINE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
    // Clears the word index and byte offset so the burst starts at the line base.
    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << (BEAT_W + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_RECOVER,
        S_DONE
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_q,  last_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   base_q,  base_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;

    // Next-state logic: arbitration in IDLE, beat sequencing through XFER/RECOVER.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        op_wr_d = op_wr_q;
        base_d  = base_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    // I wins when alone, or on a tie when D was granted last.
                    if (i_req && (!d_req || last_q == OWN_D)) begin
                        owner_d = OWN_I;
                        op_wr_d = 1'b0;
                        base_d  = i_addr & BASE_MASK;
                    end else begin
                        owner_d = OWN_D;
                        op_wr_d = d_we;
                        base_d  = d_addr & BASE_MASK;
                    end
                    beat_d  = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (mm_valid) begin
                    state_d = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = S_DONE;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                    state_d = S_XFER;
                end
            end
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; last grant resets to D.
    always_ff @(posedge MEM_CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_D;
            op_wr_q <= 1'b0;
            base_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_wr_q <= op_wr_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
        end
    end

    // Outputs decoded from registered state only; the read strobe and write data
    // are the two paths that must follow the memory/requester in the same cycle.
    always_comb begin
        busy     = (state_q != S_IDLE);
        i_gnt    = busy && (owner_q == OWN_I);
        d_gnt    = busy && (owner_q == OWN_D);
        beat     = beat_q;
        mm_re    = (state_q == S_XFER) && !op_wr_q;
        mm_we    = (state_q == S_XFER) &&  op_wr_q;
        mm_rst   = (state_q == S_RECOVER);
        done_i   = (state_q == S_DONE) && (owner_q == OWN_I);
        done_d   = (state_q == S_DONE) && (owner_q == OWN_D);
        mm_addr  = base_q | ADDR_W'({beat_q, 2'b00});
        mm_din   = mm_we ? d_wdata : '0;
        rd_valid = mm_re && mm_valid;
        rd_data  = rd_valid ? mm_dout : '0;
    end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter: refills, ties, writeback, k=0 bursts,
// spurious mm_valid and reset mid-burst.
module tb_mem_burst_arbiter;

    logic        MEM_CLK = 1'b0;
    logic        RST;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        i_gnt;
    logic        d_gnt;
    logic [2:0]  beat;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done_i;
    logic        done_d;
    logic        busy;
    logic        mm_re;
    logic        mm_we;
    logic [31:0] mm_addr;
    logic [31:0] mm_din;
    logic [31:0] mm_dout;
    logic        mm_valid;
    logic        mm_rst;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 MEM_CLK = ~MEM_CLK;

    // Writeback requester: presents the word for the current beat combinationally.
    always_comb d_wdata = 32'hA000_0000 + 32'(beat);

    mem_burst_arbiter #(
        .WORDS_PER_LINE(8),
        .ADDR_W        (32)
    ) dut (
        .MEM_CLK (MEM_CLK),
        .RST     (RST),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .i_gnt   (i_gnt),
        .d_gnt   (d_gnt),
        .beat    (beat),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .done_i  (done_i),
        .done_d  (done_d),
        .busy    (busy),
        .mm_re   (mm_re),
        .mm_we   (mm_we),
        .mm_addr (mm_addr),
        .mm_din  (mm_din),
        .mm_dout (mm_dout),
        .mm_valid(mm_valid),
        .mm_rst  (mm_rst)
    );

    task automatic step();
        @(posedge MEM_CLK);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_gnt"},    i_gnt,    0);
        check({tag, "_d_gnt"},    d_gnt,    0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_mm_re"},    mm_re,    0);
        check({tag, "_mm_we"},    mm_we,    0);
        check({tag, "_mm_rst"},   mm_rst,   0);
        check({tag, "_done_i"},   done_i,   0);
        check({tag, "_done_d"},   done_d,   0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"},  rd_data,  0);
        check({tag, "_mm_addr"},  mm_addr,  0);
        check({tag, "_mm_din"},   mm_din,   0);
        check({tag, "_beat"},     beat,     0);
    endtask

    // Runs one burst from the IDLE cycle in which the request(s) are already
    // driven. k = wait cycles before mm_valid on every beat. abort_at >= 0
    // returns at the start of that beat's XFER without finishing the burst.
    task automatic run_burst(input bit is_i, input bit is_wr, input logic [31:0] base,
                             input int unsigned k, input bit spurious, input bit drop_early,
                             input int abort_at);
        int          t0;
        logic [31:0] dout;
        t0 = cyc;
        step();
        for (int unsigned b = 0; b < 8; b++) begin
            mm_valid = 1'b0;
            if (int'(b) == abort_at) return;
            if (drop_early && b == 1) begin
                if (is_i) i_req = 1'b0;
                else      d_req = 1'b0;
            end
            check("xfer_i_gnt", i_gnt, is_i);
            check("xfer_d_gnt", d_gnt, !is_i);
            check("xfer_busy",  busy,  1);
            check("xfer_beat",  beat,  b);
            for (int unsigned j = 0; j < k; j++) begin
                check("wait_mm_re",   mm_re,   !is_wr);
                check("wait_mm_we",   mm_we,   is_wr);
                check("wait_mm_addr", mm_addr, base + 32'(b * 4));
                check("wait_mm_rst",  mm_rst,  0);
                step();
            end
            dout     = 32'hD000_0000 ^ (base + 32'(b * 4));
            mm_dout  = dout;
            mm_valid = 1'b1;
            #1;
            check("valid_mm_re",    mm_re,    !is_wr);
            check("valid_mm_we",    mm_we,    is_wr);
            check("valid_mm_addr",  mm_addr,  base + 32'(b * 4));
            check("valid_rd_valid", rd_valid, !is_wr);
            if (is_wr) check("valid_mm_din",  mm_din,  32'hA000_0000 + 32'(b));
            else       check("valid_rd_data", rd_data, dout);
            step();
            mm_valid = spurious;
            #1;
            check("rec_mm_rst",   mm_rst,   1);
            check("rec_mm_re",    mm_re,    0);
            check("rec_mm_we",    mm_we,    0);
            check("rec_rd_valid", rd_valid, 0);
            check("rec_beat",     beat,     b);
            step();
        end
        mm_valid = 1'b0;
        check("done_i",       done_i, is_i);
        check("done_d",       done_d, !is_i);
        check("done_latency", cyc - t0, 1 + 8 * (k + 2));
        check("done_mm_rst",  mm_rst, 0);
        check("done_i_gnt",   i_gnt,  is_i);
        check("done_d_gnt",   d_gnt,  !is_i);
        if (is_i) i_req = 1'b0;
        else      d_req = 1'b0;
        step();
        check("idle_busy",   busy,   0);
        check("idle_i_gnt",  i_gnt,  0);
        check("idle_d_gnt",  d_gnt,  0);
        check("idle_done_i", done_i, 0);
        check("idle_done_d", done_d, 0);
    endtask

    initial begin
        RST      = 1'b0;
        i_req    = 1'b0;
        i_addr   = 32'h0000_0104;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 32'h0000_2000;
        mm_dout  = 32'h0;
        mm_valid = 1'b0;

        // Reset values.
        step();
        step();
        step();
        check_all_zero("reset");

        // Tie right after reset: I first, then D, with mm_valid after 3 waits.
        RST   = 1'b1;
        i_req = 1'b1;
        d_req = 1'b1;
        run_burst(1'b1, 1'b0, 32'h0000_0100, 3, 1'b0, 1'b0, -1);
        run_burst(1'b0, 1'b0, 32'h0000_2000, 1, 1'b0, 1'b0, -1);

        // mm_valid in IDLE is ignored; beat stays at the last index of the burst.
        mm_valid = 1'b1;
        step();
        mm_valid = 1'b0;
        check("idle_valid_busy",  busy,  0);
        check("idle_valid_mm_re", mm_re, 0);
        check("idle_valid_beat",  beat,  7);

        // Second tie after a D grant goes to I again; then D with k=0,
        // spurious mm_valid in RECOVER and request dropped mid-burst.
        i_req = 1'b1;
        d_req = 1'b1;
        run_burst(1'b1, 1'b0, 32'h0000_0100, 0, 1'b0, 1'b0, -1);
        run_burst(1'b0, 1'b0, 32'h0000_2000, 0, 1'b1, 1'b1, -1);

        // D writeback from an unaligned line address.
        d_we   = 1'b1;
        d_addr = 32'h0000_6024;
        d_req  = 1'b1;
        run_burst(1'b0, 1'b1, 32'h0000_6020, 2, 1'b0, 1'b0, -1);

        // Reset during beat 4 of a D refill, with I pending.
        d_we   = 1'b0;
        d_addr = 32'h0000_3000;
        d_req  = 1'b1;
        run_burst(1'b0, 1'b0, 32'h0000_3000, 1, 1'b0, 1'b0, 4);
        check("abort_beat", beat, 4);
        RST   = 1'b0;
        i_req = 1'b1;
        step();
        check_all_zero("abort");
        RST = 1'b1;
        run_burst(1'b1, 1'b0, 32'h0000_0100, 0, 1'b0, 1'b0, -1);
        run_burst(1'b0, 1'b0, 32'h0000_3000, 0, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
